// File: rtl/axi_ram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_ram_slave_if
// Purpose : AXI3 single-beat bus bundle between cpu_bridge_axi (master) and
//           axi_ram_slave (slave). Lock/cache/prot are not carried.
// Signals : AR  - arid, araddr, arlen, arsize, arburst, arvalid / arready
//           R   - rid, rdata, rresp, rlast, rvalid / rready
//           AW  - awid, awaddr, awlen, awsize, awburst, awvalid / awready
//           W   - wid, wdata, wstrb, wlast, wvalid / wready
//           B   - bid, bresp, bvalid / bready
// Modports: master (bridge side), slave (memory side).
// -----------------------------------------------------------------------------
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// -----------------------------------------------------------------------------
// axi_ram_slave
// Purpose : Single-port AXI3 slave RAM serving single-beat transfers, one
//           outstanding read and one outstanding write, with independent read
//           and write FSMs. Word array of 2^(AW-2) 32-bit words, not reset.
// Params  : AW  - byte-address bits decoded (index = addr[AW-1:2])
//           LAT - cycles from request acceptance / write commit to response
//                 valid, 1..15
// Ports   : aclk    - clock
//           aresetn - synchronous active-low reset
//           axi     - axi_ram_slave_if.slave bus bundle (AR/R/AW/W/B)
// Config  : define AXI_RAM_RAND_DELAY_EN to gate the idle readies with an
//           LFSR bit and add lfsr[2:1] to each response latency (saturating
//           at 15). Without it, readies and latency are fully deterministic.
// -----------------------------------------------------------------------------
module axi_ram_slave #(
  parameter int AW  = 14,
  parameter int LAT = 2
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi_ram_slave_if.slave axi
);

  localparam int DEPTH = 1 << (AW - 2);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] LAT_C = 4'(LAT);

  // Byte-lane merge of a new word into an old one under a byte strobe.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] mem_q [DEPTH];

  logic       ready_gate_s;
  logic [3:0] load_lat_s;

`ifdef AXI_RAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  lat_sum_s;

  // Fibonacci LFSR next value, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR free-runs every cycle from a fixed seed.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Readies are registered, so gate them with the value lfsr_q will hold
  // in the cycle the ready is visible.
  assign ready_gate_s = lfsr_d[0];
  assign lat_sum_s    = {1'b0, LAT_C} + {3'b000, lfsr_q[2:1]};
  assign load_lat_s   = (lat_sum_s > 5'd15) ? 4'd15 : lat_sum_s[3:0];
`else
  assign ready_gate_s = 1'b1;
  assign load_lat_s   = LAT_C;
`endif

  // Ignored bus fields.
  logic unused_s;
  assign unused_s = ^{axi.araddr[31:AW], axi.araddr[1:0], axi.arsize, axi.arburst,
                      axi.awaddr[31:AW], axi.awaddr[1:0], axi.awsize, axi.awburst,
                      axi.wid, axi.wlast};

  // ---------------------------------------------------------------- read path
  logic [1:0]      r_state_q, r_state_d;
  logic [3:0]      r_cnt_q, r_cnt_d;
  logic [AW-3:0]   r_idx_q, r_idx_d;
  logic [3:0]      r_id_q, r_id_d;
  logic            r_len_nz_q, r_len_nz_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      rid_q, rid_d;
  logic [1:0]      rresp_q, rresp_d;

  // ---------------------------------------------------------------- write path
  logic [1:0]      w_state_q, w_state_d;
  logic [3:0]      w_cnt_q, w_cnt_d;
  logic            aw_got_q, aw_got_d;
  logic            w_got_q, w_got_d;
  logic [AW-3:0]   aw_idx_q, aw_idx_d;
  logic [3:0]      aw_id_q, aw_id_d;
  logic            aw_len_nz_q, aw_len_nz_d;
  logic [31:0]     w_data_q, w_data_d;
  logic [3:0]      w_strb_q, w_strb_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [3:0]      bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;

  logic            ar_hs_s, aw_hs_s, w_hs_s, commit_s;
  logic [AW-3:0]   wr_idx_s;
  logic [31:0]     wr_data_s, merged_s, rd_word_s;
  logic [3:0]      wr_strb_s;

  assign ar_hs_s = arready_q & axi.arvalid;
  assign aw_hs_s = awready_q & axi.awvalid;
  assign w_hs_s  = wready_q  & axi.wvalid;

  // Commit happens in the cycle both halves are present, whether latched
  // earlier or arriving now; the payload comes from wherever it currently is.
  assign commit_s  = (w_state_q == W_IDLE) & (aw_got_q | aw_hs_s) & (w_got_q | w_hs_s);
  assign wr_idx_s  = aw_got_q ? aw_idx_q : axi.awaddr[AW-1:2];
  assign wr_data_s = w_got_q  ? w_data_q : axi.wdata;
  assign wr_strb_s = w_got_q  ? w_strb_q : axi.wstrb;
  assign merged_s  = merge_bytes(mem_q[wr_idx_s], wr_data_s, wr_strb_s);

  // Write-first: a capture colliding with a commit sees the merged word.
  assign rd_word_s = (commit_s && (wr_idx_s == r_idx_q)) ? merged_s : mem_q[r_idx_q];

  // Read FSM next-state and R channel output registers.
  always_comb begin
    r_state_d  = r_state_q;
    r_cnt_d    = r_cnt_q;
    r_idx_d    = r_idx_q;
    r_id_d     = r_id_q;
    r_len_nz_d = r_len_nz_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d  = R_WAIT;
          r_cnt_d    = load_lat_s;
          r_idx_d    = axi.araddr[AW-1:2];
          r_id_d     = axi.arid;
          r_len_nz_d = (axi.arlen != 8'd0);
        end else begin
          r_state_d  = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_cnt_q <= 4'd1) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rlast_d   = 1'b1;
          rdata_d   = rd_word_s;
          rid_d     = r_id_q;
          rresp_d   = r_len_nz_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
          r_cnt_d   = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rvalid_q && axi.rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
    arready_d = (r_state_d == R_IDLE) & ready_gate_s;
  end

  // Write FSM next-state, got flags, payload latches and B output registers.
  always_comb begin
    w_state_d   = w_state_q;
    w_cnt_d     = w_cnt_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    aw_idx_d    = aw_idx_q;
    aw_id_d     = aw_id_q;
    aw_len_nz_d = aw_len_nz_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_got_d    = 1'b1;
          aw_idx_d    = axi.awaddr[AW-1:2];
          aw_id_d     = axi.awid;
          aw_len_nz_d = (axi.awlen != 8'd0);
        end else begin
          aw_got_d    = aw_got_q;
        end
        if (w_hs_s) begin
          w_got_d  = 1'b1;
          w_data_d = axi.wdata;
          w_strb_d = axi.wstrb;
        end else begin
          w_got_d  = w_got_q;
        end
        if (commit_s) begin
          w_state_d = W_WAIT;
          w_cnt_d   = load_lat_s;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        if (w_cnt_q <= 4'd1) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bid_d     = aw_id_q;
          bresp_d   = aw_len_nz_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
          w_cnt_d   = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bvalid_q && axi.bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
      end
    endcase
    awready_d = (w_state_d == W_IDLE) & ~aw_got_d & ready_gate_s;
    wready_d  = (w_state_d == W_IDLE) & ~w_got_d  & ready_gate_s;
  end

  // State and output registers; readies stay low for the first cycle after
  // reset because they are loaded only on an edge that sees aresetn high.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q   <= R_IDLE;
      r_cnt_q     <= 4'd0;
      r_idx_q     <= '0;
      r_id_q      <= 4'd0;
      r_len_nz_q  <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= 32'd0;
      rid_q       <= 4'd0;
      rresp_q     <= 2'd0;
      w_state_q   <= W_IDLE;
      w_cnt_q     <= 4'd0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      aw_idx_q    <= '0;
      aw_id_q     <= 4'd0;
      aw_len_nz_q <= 1'b0;
      w_data_q    <= 32'd0;
      w_strb_q    <= 4'd0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= 4'd0;
      bresp_q     <= 2'd0;
    end else begin
      r_state_q   <= r_state_d;
      r_cnt_q     <= r_cnt_d;
      r_idx_q     <= r_idx_d;
      r_id_q      <= r_id_d;
      r_len_nz_q  <= r_len_nz_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      rid_q       <= rid_d;
      rresp_q     <= rresp_d;
      w_state_q   <= w_state_d;
      w_cnt_q     <= w_cnt_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      aw_idx_q    <= aw_idx_d;
      aw_id_q     <= aw_id_d;
      aw_len_nz_q <= aw_len_nz_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
    end
  end

  // Memory array write; contents survive reset, and nothing commits while
  // reset is asserted so a half-received write is dropped.
  always_ff @(posedge aclk) begin
    if (aresetn && commit_s) begin
      mem_q[wr_idx_s] <= merged_s;
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rdata   = rdata_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_ram_slave
// Purpose : Directed self-checking bench for axi_ram_slave (AW=14, LAT=2,
//           AXI_RAM_RAND_DELAY_EN undefined). Inputs change on the falling
//           edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_ram_slave;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  axi_ram_slave_if axi ();

  axi_ram_slave #(.AW(14), .LAT(LAT)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .axi     (axi)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_arready"}, {31'd0, axi.arready}, 32'd0);
    check_eq({tag, "_awready"}, {31'd0, axi.awready}, 32'd0);
    check_eq({tag, "_wready"},  {31'd0, axi.wready},  32'd0);
    check_eq({tag, "_rvalid"},  {31'd0, axi.rvalid},  32'd0);
    check_eq({tag, "_bvalid"},  {31'd0, axi.bvalid},  32'd0);
    check_eq({tag, "_rlast"},   {31'd0, axi.rlast},   32'd0);
    check_eq({tag, "_rdata"},   axi.rdata,            32'd0);
    check_eq({tag, "_rid"},     {28'd0, axi.rid},     32'd0);
    check_eq({tag, "_rresp"},   {30'd0, axi.rresp},   32'd0);
    check_eq({tag, "_bid"},     {28'd0, axi.bid},     32'd0);
    check_eq({tag, "_bresp"},   {30'd0, axi.bresp},   32'd0);
  endtask

  // AW and W presented in the same cycle.
  task automatic send_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id,
                            input logic [7:0] len);
    int n = 0;
    while (!(axi.awready && axi.wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_ready", {31'd0, axi.awready && axi.wready}, 32'd1);
    axi.awvalid = 1'b1; axi.awaddr = addr; axi.awid = id; axi.awlen = len;
    axi.wvalid  = 1'b1; axi.wdata  = data; axi.wstrb = strb; axi.wid = id;
    axi.wlast   = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
  endtask

  task automatic take_b(input string tag, input int exp_lat,
                        input logic [3:0] id, input logic [1:0] resp);
    int lat = 0;
    while (!axi.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_blat"},  32'(lat), 32'(exp_lat));
    check_eq({tag, "_bid"},   {28'd0, axi.bid},   {28'd0, id});
    check_eq({tag, "_bresp"}, {30'd0, axi.bresp}, {30'd0, resp});
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check_eq({tag, "_bdone"}, {31'd0, axi.bvalid}, 32'd0);
  endtask

  task automatic send_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    while (!axi.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ar_ready", {31'd0, axi.arready}, 32'd1);
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id; axi.arlen = len;
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_r(input string tag, input int exp_lat);
    int lat = 0;
    while (!axi.rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_rlat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take_r(input string tag, input int exp_lat, input logic [31:0] data,
                        input logic [3:0] id, input logic [1:0] resp);
    wait_r(tag, exp_lat);
    check_eq({tag, "_rdata"}, axi.rdata, data);
    check_eq({tag, "_rid"},   {28'd0, axi.rid},   {28'd0, id});
    check_eq({tag, "_rresp"}, {30'd0, axi.rresp}, {30'd0, resp});
    check_eq({tag, "_rlast"}, {31'd0, axi.rlast}, 32'd1);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check_eq({tag, "_rdone"}, {31'd0, axi.rvalid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    axi.arid = 4'd0; axi.araddr = 32'd0; axi.arlen = 8'd0; axi.arsize = 3'd2;
    axi.arburst = 2'd1; axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi.awid = 4'd0; axi.awaddr = 32'd0; axi.awlen = 8'd0; axi.awsize = 3'd2;
    axi.awburst = 2'd1; axi.awvalid = 1'b0;
    axi.wid = 4'd0; axi.wdata = 32'd0; axi.wstrb = 4'd0; axi.wlast = 1'b0;
    axi.wvalid = 1'b0; axi.bready = 1'b0;

    // Reset state and ready release timing.
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    check_eq("post_rst_arready", {31'd0, axi.arready}, 32'd0);
    check_eq("post_rst_wready",  {31'd0, axi.wready},  32'd0);
    @(negedge clk);
    check_eq("idle_arready", {31'd0, axi.arready}, 32'd1);
    check_eq("idle_awready", {31'd0, axi.awready}, 32'd1);
    check_eq("idle_wready",  {31'd0, axi.wready},  32'd1);

    // Same-cycle AW/W, then read back.
    send_write(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd1, 8'd0);
    take_b("t1", LAT, 4'd1, 2'b00);
    send_read(32'h0000_0100, 4'd0, 8'd0);
    take_r("t1", LAT, 32'hDEAD_BEEF, 4'd0, 2'b00);

    // W first, AW three cycles later, single byte lane.
    send_write(32'h0000_0104, 32'h1122_3344, 4'hF, 4'd2, 8'd0);
    take_b("t2a", LAT, 4'd2, 2'b00);
    axi.wvalid = 1'b1; axi.wdata = 32'h0000_AB00; axi.wstrb = 4'b0010; axi.wid = 4'd3;
    @(negedge clk);
    axi.wvalid = 1'b0;
    check_eq("t2_wready0", {31'd0, axi.wready}, 32'd0);
    @(negedge clk);
    check_eq("t2_wready1", {31'd0, axi.wready}, 32'd0);
    check_eq("t2_awready", {31'd0, axi.awready}, 32'd1);
    @(negedge clk);
    check_eq("t2_wready2", {31'd0, axi.wready}, 32'd0);
    axi.awvalid = 1'b1; axi.awaddr = 32'h0000_0104; axi.awid = 4'd3; axi.awlen = 8'd0;
    @(negedge clk);
    axi.awvalid = 1'b0;
    take_b("t2b", LAT, 4'd3, 2'b00);
    send_read(32'h0000_0104, 4'd4, 8'd0);
    take_r("t2", LAT, 32'h1122_AB44, 4'd4, 2'b00);

    // R channel held under back-pressure for five cycles.
    send_read(32'h0000_0100, 4'd5, 8'd0);
    wait_r("t3", LAT);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_rvalid",  {31'd0, axi.rvalid},  32'd1);
      check_eq("t3_rdata",   axi.rdata,            32'hDEAD_BEEF);
      check_eq("t3_rid",     {28'd0, axi.rid},     32'd5);
      check_eq("t3_arready", {31'd0, axi.arready}, 32'd0);
      @(negedge clk);
    end
    axi.rready = 1'b1;
    check_eq("t3_arready_hs", {31'd0, axi.arready}, 32'd0);
    @(negedge clk);
    axi.rready = 1'b0;
    check_eq("t3_rdone",       {31'd0, axi.rvalid},  32'd0);
    check_eq("t3_arready_aft", {31'd0, axi.arready}, 32'd1);

    // Read capture and write commit to the same word in the same cycle.
    send_write(32'h0000_0200, 32'h0000_0000, 4'hF, 4'd6, 8'd0);
    take_b("t4a", LAT, 4'd6, 2'b00);
    send_read(32'h0000_0200, 4'd7, 8'd0);
    @(negedge clk);
    send_write(32'h0000_0200, 32'h5A5A_5A5A, 4'hF, 4'd8, 8'd0);
    take_r("t4", 0, 32'h5A5A_5A5A, 4'd7, 2'b00);
    take_b("t4b", 1, 4'd8, 2'b00);

    // Burst requests: single beat with SLVERR; empty strobe writes nothing.
    send_read(32'h0000_0100, 4'd9, 8'd3);
    take_r("t5", LAT, 32'hDEAD_BEEF, 4'd9, 2'b10);
    @(negedge clk);
    check_eq("t5_no_beat2", {31'd0, axi.rvalid}, 32'd0);
    send_write(32'h0000_0108, 32'h0BAD_CAFE, 4'hF, 4'd10, 8'd1);
    take_b("t5w", LAT, 4'd10, 2'b10);
    send_write(32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 4'd11, 8'd0);
    take_b("t5z", LAT, 4'd11, 2'b00);
    send_read(32'h0000_0100, 4'd12, 8'd0);
    take_r("t5z", LAT, 32'hDEAD_BEEF, 4'd12, 2'b00);

    // Reset during W_WAIT: no B response, committed data kept.
    send_write(32'h0000_0300, 32'hCAFE_F00D, 4'hF, 4'd12, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t6_no_b", {31'd0, axi.bvalid}, 32'd0);
    end

    // Half-received write (AW only) dropped by reset.
    send_write(32'h0000_0304, 32'h1111_1111, 4'hF, 4'd1, 8'd0);
    take_b("t6a", LAT, 4'd1, 2'b00);
    axi.awvalid = 1'b1; axi.awaddr = 32'h0000_0304; axi.awid = 4'd2; axi.awlen = 8'd0;
    @(negedge clk);
    axi.awvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_write(32'h0000_0308, 32'h4444_4444, 4'hF, 4'd3, 8'd0);
    take_b("t6c", LAT, 4'd3, 2'b00);
    send_read(32'h0000_0300, 4'd4, 8'd0);
    take_r("t6_300", LAT, 32'hCAFE_F00D, 4'd4, 2'b00);
    send_read(32'h0000_0304, 4'd5, 8'd0);
    take_r("t6_304", LAT, 32'h1111_1111, 4'd5, 2'b00);
    send_read(32'h0000_0308, 4'd6, 8'd0);
    take_r("t6_308", LAT, 32'h4444_4444, 4'd6, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

Single-port AXI3 slave memory sitting directly downstream of `cpu_bridge_axi`; it consumes the bridge's AR/R/AW/W/B channels and serves them from an internal word array. It supports exactly the traffic the bridge generates: single-beat transfers, one outstanding read and one outstanding write, with independent read and write paths. It is the memory model for the SoC top and the bridge's verification target.

## Interface
- `AW`, default 14: byte-address bits decoded; memory holds 2^(AW-2) 32-bit words, index = `addr[AW-1:2]`; upper bits ignored.
- `LAT`, default 2: cycles from request acceptance to response valid; legal range 1..15.
- `aclk` in 1: clock.
- `aresetn` in 1: synchronous, active-low reset.
- `arid` in 4, `araddr` in 32, `arlen` in 8, `arsize` in 3, `arburst` in 2, `arvalid` in 1: read address channel.
- `arready` out 1: read address accept.
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1: read data channel.
- `rready` in 1: master accepts read data.
- `awid` in 4, `awaddr` in 32, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awvalid` in 1: write address channel.
- `awready` out 1: write address accept.
- `wid` in 4, `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1: write data channel.
- `wready` out 1: write data accept.
- `bid` out 4, `bresp` out 2, `bvalid` out 1: write response channel.
- `bready` in 1: master accepts write response.
- Lock/cache/prot from the bridge are left unconnected at the top level.

## Operation
- Read FSM, states R_IDLE → R_WAIT → R_RESP → R_IDLE.
  - R_IDLE: `arready`=1. On handshake, latch `arid`, word index, and `arlen!=0`; load counter with LAT.
  - R_WAIT: decrement each cycle. When the counter reaches 1, capture `mem[index]` into the `rdata` register and go to R_RESP.
  - R_RESP: `rvalid`=1 and `rlast`=1. `rid` = latched id. `rresp` = 2'b00, or 2'b10 (SLVERR) if the latched `arlen!=0`; bursts are never expanded.
  - Hold all R outputs stable until `rready`, then return to R_IDLE. `arready`=0 outside R_IDLE.
- Write FSM, states W_IDLE → W_WAIT → W_RESP → W_IDLE.
  - W_IDLE: `awready` = !aw_got and `wready` = !w_got. AW and W are accepted in either order or in the same cycle; each sets its got flag and latches its payload.
  - Commit cycle: the cycle both flags are (or become) set. Write `mem[index]` byte-wise under `wstrb`; `wstrb`=0 writes nothing. Load counter with LAT and enter W_WAIT.
  - W_WAIT counts down to W_RESP. W_RESP: `bvalid`=1, `bid` = latched `awid`. `bresp` = 2'b00, or 2'b10 if `awlen!=0`. Hold until `bready`, then clear the got flags and return to W_IDLE.
  - `awid`/`wid` mismatch is ignored; `wlast` is ignored.
- Read/write collision: a read capture in the same cycle as a write commit to the same index returns the post-write (merged) word; reads are write-first.
- `arsize`/`awsize`/`arburst`/`awburst` are ignored; byte selection is by `wstrb` only and reads always return the full word.
- Memory contents are not initialized by reset.

## Timing
- During reset and in the first cycle after it: `arready`=`awready`=`wready`=0. All other outputs are 0: `rvalid`, `bvalid`, `rlast`, `rdata`, `rid`, `rresp`, `bid`, `bresp`. From the second cycle after reset, the idle readies are 1.
- AR handshake at cycle t gives `rvalid` at t+LAT. Commit at cycle c gives `bvalid` at c+LAT.
- Earliest next AR is the cycle after the R handshake; no same-cycle R-done/AR-accept overlap.
- Reset asserted mid-transaction aborts both FSMs to idle. Any committed write persists; an uncommitted half-received write is dropped.

## Configuration
- `AXI_RAM_RAND_DELAY_EN` defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - The idle readies are additionally ANDed with `lfsr[0]`.
  - Each response latency becomes LAT + `lfsr[2:1]`, sampled at acceptance or commit; the 4-bit counter saturates at 15.
- Undefined: readies are exactly as described above and latency is exactly LAT. The LFSR is absent.

## Test plan
- Reset, then AW 0x100 and W 0xDEADBEEF with `wstrb`=4'hF in the same cycle → `bvalid` at commit+2, `bid`=1, `bresp`=0. Then AR 0x100 with id 0 → `rvalid` 2 cycles after the handshake, `rdata`=0xDEADBEEF, `rlast`=1.
- W first, AW 3 cycles later; `wstrb`=4'b0010, `wdata`=0x0000AB00 onto 0x11223344 → read returns 0x1122AB44; `wready`=0 while waiting for AW.
- `rready` held low 5 cycles in R_RESP → `rvalid`/`rdata`/`rid` stable; `arready`=0 until the cycle after the handshake.
- Write commit and read capture to 0x200 in the same cycle, old 0, new 0x5A5A5A5A → `rdata`=0x5A5A5A5A.
- AR with `arlen`=3 → single beat, `rresp`=2'b10, `rlast`=1.
- `aresetn` low during W_WAIT → `bvalid` never asserts; the subsequent read of that address returns the committed data.
